mask_bit_scanner: RTL and testbench

Serial consumer of 32-bit bitwise masks produced by the datapath's logic units (e.g. the 32-bit AND stage). It accepts one mask word per valid/ready handshake and emits, one per output handshake, the index of every set bit in ascending order. It tags each output beat with a sequence number and a last flag. It sits between the bitwise logic stage and the sparse-activation/address-generation logic of the TPU, converting a mask into a stream of lane indices.

---
 rtl/tpu_mask_pkg.sv | 12 +
 rtl/lsb_prienc.sv | 24 ++
 rtl/mask_bit_scanner.sv | 83 ++++++++
 tb/tb_mask_bit_scanner.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/tpu_mask_pkg.sv
// Shared constants and scanner state type for the mask-to-index path.
package tpu_mask_pkg;

  localparam int MASK_W     = 32;
  localparam int MASK_IDX_W = 5;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } scan_state_t;

endpackage

// File: rtl/lsb_prienc.sv
// Lowest-set-bit priority encoder with any/one-hot flags; purely combinational.
// An all-zero vector reports index 0 with any=0.
module lsb_prienc #(
  parameter  int WIDTH = 32,
  localparam int IDX_W = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] vec,
  output logic [IDX_W-1:0] idx,
  output logic             any,
  output logic             onehot
);

  // Scan from the top down so the lowest set bit is the final assignment.
  always_comb begin
    idx = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (vec[i]) idx = IDX_W'(i);
    end
  end

  assign any    = |vec;
  assign onehot = any && ((vec & (vec - WIDTH'(1))) == '0);

endmodule

// File: rtl/mask_bit_scanner.sv
// Turns one mask word into a stream of set-bit indices; first beat one cycle after accept,
// one beat per cycle after that; out_valid holds under stall, in_ready low while scanning.
module mask_bit_scanner
  import tpu_mask_pkg::*;
#(
  parameter  int WIDTH = MASK_W,
  localparam int IDX_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_mask,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDX_W-1:0] out_index,
  output logic [IDX_W:0]   out_seq,
  output logic             out_last,
  output logic             out_zero
);

  scan_state_t      state;
  logic [WIDTH-1:0] rem;
  logic [IDX_W:0]   seq;
  logic             zero;

  logic [IDX_W-1:0] low_idx;
  logic             any;
  logic             onehot;
  logic             scan;
  logic [WIDTH-1:0] rem_next;

  lsb_prienc #(.WIDTH(WIDTH)) u_prienc (
    .vec    (rem),
    .idx    (low_idx),
    .any    (any),
    .onehot (onehot)
  );

  // Handshake signals come from the state register alone, never from out_ready.
  assign scan      = (state == SCAN);
  assign in_ready  = (state == IDLE);
  assign out_valid = scan;
  assign out_index = any ? low_idx : '0;
  assign out_seq   = seq;
  assign out_last  = scan && (onehot || zero);
  assign out_zero  = scan && zero;

  assign rem_next = rem & ~(WIDTH'(1) << low_idx);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      rem   <= '0;
      seq   <= '0;
      zero  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            rem   <= in_mask;
            seq   <= '0;
            zero  <= (in_mask == '0);
            state <= SCAN;
          end
        end
        SCAN: begin
          if (out_ready) begin
            rem <= rem_next;
            seq <= seq + (IDX_W + 1)'(1);
            // No accept on the last beat: the next word waits for the IDLE cycle.
            if (out_last) begin
              zero  <= 1'b0;
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mask_bit_scanner.sv
// Table, hand-written and randomized checks of mask_bit_scanner against a bit-list model.
module tb_mask_bit_scanner;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_mask;
  logic        out_valid;
  logic        out_ready;
  logic [4:0]  out_index;
  logic [5:0]  out_seq;
  logic        out_last;
  logic        out_zero;

  int nvec = 0;
  int nbad = 0;

  mask_bit_scanner #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_mask   (in_mask),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_index (out_index),
    .out_seq   (out_seq),
    .out_last  (out_last),
    .out_zero  (out_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    int idx;
    int seq;
    bit last;
    bit zero;
  } beat_t;

  typedef struct {
    logic [31:0] mask;
    int          beats;
    int          last_idx;
    int          cycles;
  } vec_t;

  task automatic chk(input string name, input longint act, input longint exp);
    nvec++;
    if (act != exp) begin
      nbad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Offers one word, drains it with out_ready asserted ready_pct% of cycles, and
  // checks every beat against the list of set bits of m.
  task automatic send_word(input logic [31:0] m, input int ready_pct,
                           output int cycles, output int nbeats, output int last_idx);
    beat_t q[$];
    int    cnt;
    int    guard;
    int    total;
    bit    r;
    total = $countones(m);
    cnt = 0;
    for (int i = 0; i < 32; i++) begin
      if (m[i]) begin
        q.push_back('{idx: i, seq: cnt, last: (cnt + 1 == total), zero: 1'b0});
        cnt++;
      end
    end
    if (total == 0) q.push_back('{idx: 0, seq: 0, last: 1'b1, zero: 1'b1});

    guard = 0;
    while (!in_ready && guard < 100) begin
      tick();
      guard++;
    end
    chk("wait_in_ready", longint'(in_ready), 1);
    in_valid = 1'b1;
    in_mask  = m;
    tick();
    in_valid = 1'b0;
    in_mask  = $urandom;
    cycles   = 1;
    nbeats   = 0;
    last_idx = -1;
    guard    = 0;
    while (q.size() > 0 && guard < 600) begin
      chk("out_valid", longint'(out_valid), 1);
      chk("in_ready_busy", longint'(in_ready), 0);
      chk("out_index", longint'(out_index), q[0].idx);
      chk("out_seq", longint'(out_seq), q[0].seq);
      chk("out_last", longint'(out_last), longint'(q[0].last));
      chk("out_zero", longint'(out_zero), longint'(q[0].zero));
      r = ($urandom_range(99) < ready_pct);
      out_ready = r;
      if (r && out_valid) begin
        nbeats++;
        if (out_last) last_idx = int'(out_index);
      end
      tick();
      cycles++;
      guard++;
      if (r) void'(q.pop_front());
    end
    if (q.size() != 0) chk("drain_timeout", q.size(), 0);
    out_ready = 1'b0;
    chk("idle_out_valid", longint'(out_valid), 0);
    chk("idle_in_ready", longint'(in_ready), 1);
  endtask

  vec_t tbl[6];
  int   cyc, nb, li;
  logic [31:0] rm;

  initial begin
    tbl[0] = '{mask: 32'h0000_0000, beats: 1,  last_idx: 0,  cycles: 2};
    tbl[1] = '{mask: 32'h8000_0011, beats: 3,  last_idx: 31, cycles: 4};
    tbl[2] = '{mask: 32'hFFFF_FFFF, beats: 32, last_idx: 31, cycles: 33};
    tbl[3] = '{mask: 32'h0000_0001, beats: 1,  last_idx: 0,  cycles: 2};
    tbl[4] = '{mask: 32'h8000_0000, beats: 1,  last_idx: 31, cycles: 2};
    tbl[5] = '{mask: 32'hAAAA_AAAA, beats: 16, last_idx: 31, cycles: 17};

    // Reset with in_valid high must not accept anything.
    rst = 1'b1; in_valid = 1'b1; in_mask = 32'hFFFF_FFFF; out_ready = 1'b0;
    tick();
    tick();
    chk("rst_in_ready", longint'(in_ready), 1);
    chk("rst_out_valid", longint'(out_valid), 0);
    chk("rst_out_index", longint'(out_index), 0);
    chk("rst_out_seq", longint'(out_seq), 0);
    chk("rst_out_last", longint'(out_last), 0);
    chk("rst_out_zero", longint'(out_zero), 0);
    rst = 1'b0; in_valid = 1'b0;
    tick();
    chk("post_rst_no_accept", longint'(out_valid), 0);

    for (int v = 0; v < 6; v++) begin
      send_word(tbl[v].mask, 100, cyc, nb, li);
      chk("tbl_cycles", cyc, tbl[v].cycles);
      chk("tbl_beats", nb, tbl[v].beats);
      chk("tbl_last_idx", li, tbl[v].last_idx);
    end

    // Stall on 0x6 with in_valid held high, then next word follows after one idle cycle.
    in_valid = 1'b1; in_mask = 32'h0000_0006;
    tick();
    in_mask = 32'h0000_0008;
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("stall_valid", longint'(out_valid), 1);
      chk("stall_index", longint'(out_index), 1);
      chk("stall_in_ready", longint'(in_ready), 0);
      tick();
    end
    out_ready = 1'b1;
    chk("stall_rel_index", longint'(out_index), 1);
    chk("stall_rel_last", longint'(out_last), 0);
    tick();
    chk("stall_second_index", longint'(out_index), 2);
    chk("stall_second_seq", longint'(out_seq), 1);
    chk("stall_second_last", longint'(out_last), 1);
    tick();
    chk("turn_out_valid", longint'(out_valid), 0);
    chk("turn_in_ready", longint'(in_ready), 1);
    tick();
    in_valid = 1'b0;
    chk("next_word_index", longint'(out_index), 3);
    chk("next_word_last", longint'(out_last), 1);
    tick();

    // Back-to-back 0x1 then 0x2 with in_valid always high.
    in_valid = 1'b1; in_mask = 32'h0000_0001; out_ready = 1'b1;
    tick();
    in_mask = 32'h0000_0002;
    chk("b2b_first_index", longint'(out_index), 0);
    chk("b2b_first_last", longint'(out_last), 1);
    tick();
    chk("b2b_gap_valid", longint'(out_valid), 0);
    tick();
    in_valid = 1'b0;
    chk("b2b_second_valid", longint'(out_valid), 1);
    chk("b2b_second_index", longint'(out_index), 1);
    chk("b2b_second_seq", longint'(out_seq), 0);
    chk("b2b_second_last", longint'(out_last), 1);
    tick();
    out_ready = 1'b0;

    // Reset mid-scan after two beats discards the rest of the word.
    in_valid = 1'b1; in_mask = 32'hF0F0_F0F0;
    tick();
    in_valid = 1'b0; out_ready = 1'b1;
    chk("mid_beat0", longint'(out_index), 4);
    tick();
    chk("mid_beat1", longint'(out_index), 5);
    tick();
    out_ready = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_valid", longint'(out_valid), 0);
    chk("mid_rst_in_ready", longint'(in_ready), 1);
    chk("mid_rst_seq", longint'(out_seq), 0);
    send_word(32'h0000_0100, 100, cyc, nb, li);
    chk("mid_rst_beats", nb, 1);

    // Randomized masks and backpressure.
    for (int n = 0; n < 60; n++) begin
      case ($urandom_range(3))
        0: rm = $urandom;
        1: rm = $urandom & $urandom & $urandom;
        2: rm = 32'h1 << $urandom_range(31);
        default: rm = ($urandom_range(3) == 0) ? 32'h0 : ($urandom & $urandom & $urandom & $urandom);
      endcase
      send_word(rm, 40 + $urandom_range(60), cyc, nb, li);
      chk("rand_beats", nb, ($countones(rm) == 0) ? 1 : $countones(rm));
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end

endmodule
